// File: rtl/pc_sequencer.sv
// Next-PC selection and run/halt sequencing for the 8-bit single-cycle core.
// Branch opcodes carry a LUT index on the ALU result; index 0 falls through to pc+1.
module pc_sequencer #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              stall,
  input  logic [3:0]        opcode,
  input  logic [7:0]        alu_rslt,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_en,
  output logic              branch_taken,
  output logic              done,
  output logic              tgt_err
);

  localparam int LUT_DEPTH = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              bt_q, bt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   lut_q [LUT_DEPTH];

  logic              fetch_en_s;
  logic              is_branch_s;
  logic              idx_zero_s;
  logic              idx_in_range_s;
  logic [PC_W-1:0]   lut_rd_s;
  logic [PC_W-1:0]   pc_inc_s;

  assign fetch_en_s     = (state_q == S_RUN) && !stall;
  assign is_branch_s    = (opcode == 4'b1100) || (opcode == 4'b1101) || (opcode == 4'b1110);
  assign idx_zero_s     = (alu_rslt == 8'd0);
  assign idx_in_range_s = ((alu_rslt >> LUT_AW) == 8'd0);
  // Reads registered storage, so a same-cycle write is only seen next cycle.
  assign lut_rd_s       = lut_q[alu_rslt[LUT_AW-1:0]];
  assign pc_inc_s       = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Branch-target LUT; entry 0 is hardwired to stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we && (lut_waddr != '0)) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // Sequencer state, PC and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      bt_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bt_q    <= bt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bt_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = start_addr;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!fetch_en_s) begin
          pc_d = pc_q;
        end else if (opcode == 4'b1111) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (is_branch_s && !idx_zero_s && idx_in_range_s) begin
          pc_d = lut_rd_s;
          bt_d = 1'b1;
        end else if (is_branch_s && !idx_in_range_s) begin
          pc_d  = pc_inc_s;
          err_d = 1'b1;
        end else begin
          pc_d = pc_inc_s;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = start_addr;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign pc           = pc_q;
  assign fetch_en     = fetch_en_s;
  assign branch_taken = bt_q;
  assign done         = done_q;
  assign tgt_err      = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [PC_W-1:0]   start_addr;
  logic              stall;
  logic [3:0]        opcode;
  logic [7:0]        alu_rslt;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic              branch_taken;
  logic              done;
  logic              tgt_err;

  int checks;
  int failures;

  pc_sequencer #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .opcode       (opcode),
    .alu_rslt     (alu_rslt),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .pc           (pc),
    .fetch_en     (fetch_en),
    .branch_taken (branch_taken),
    .done         (done),
    .tgt_err      (tgt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [7:0] rs);
    opcode   = op;
    alu_rslt = rs;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 10'h000;
    stall      = 1'b0;
    opcode     = 4'h0;
    alu_rslt   = 8'h00;
    lut_we     = 1'b0;
    lut_waddr  = 5'd0;
    lut_wdata  = 10'h000;

    #12;
    check("rst_pc", 16'(pc), 16'h0000);
    check("rst_fetch_en", 16'(fetch_en), 16'h0000);
    check("rst_bt", 16'(branch_taken), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    check("rst_tgt_err", 16'(tgt_err), 16'h0000);
    rst_n = 1'b1;

    // start and straight-line execution; start ignored while running
    start = 1'b1; start_addr = 10'h010;
    step();
    check("start_pc", 16'(pc), 16'h0010);
    start = 1'b0; set_op(4'h7, 8'h00);
    #1 check("run_fetch_en", 16'(fetch_en), 16'h0001);
    step(); check("seq_pc1", 16'(pc), 16'h0011);
    step(); check("seq_pc2", 16'(pc), 16'h0012);
    start = 1'b1; start_addr = 10'h200;
    step(); check("seq_pc3", 16'(pc), 16'h0013);
    check("seq_bt", 16'(branch_taken), 16'h0000);
    start = 1'b0;

    // LUT write then beq taken, bne with index 0
    lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h123;
    step(); check("wr_pc", 16'(pc), 16'h0014);
    lut_we = 1'b0; set_op(4'hC, 8'd3);
    step(); check("beq_pc", 16'(pc), 16'h0123);
    check("beq_bt", 16'(branch_taken), 16'h0001);
    set_op(4'hD, 8'd0);
    step(); check("bne0_pc", 16'(pc), 16'h0124);
    check("bne0_bt", 16'(branch_taken), 16'h0000);

    // out-of-range indices set the sticky error
    set_op(4'hE, 8'h40);
    step(); check("jmp40_pc", 16'(pc), 16'h0125);
    check("jmp40_err", 16'(tgt_err), 16'h0001);
    check("jmp40_bt", 16'(branch_taken), 16'h0000);
    set_op(4'hC, 8'h20);
    step(); check("beq20_pc", 16'(pc), 16'h0126);
    set_op(4'h7, 8'h00);
    step(); check("err_sticky_pc", 16'(pc), 16'h0127);
    check("err_sticky", 16'(tgt_err), 16'h0001);

    // stall holds everything
    stall = 1'b1;
    #1 check("stall_fetch_en", 16'(fetch_en), 16'h0000);
    repeat (4) step();
    check("stall_pc", 16'(pc), 16'h0127);
    check("stall_fetch_en2", 16'(fetch_en), 16'h0000);

    // done opcode halts
    stall = 1'b0; set_op(4'hF, 8'h00);
    step(); check("halt_done", 16'(done), 16'h0001);
    check("halt_pc", 16'(pc), 16'h0127);
    check("halt_fetch_en", 16'(fetch_en), 16'h0000);
    step(); check("halt_pc2", 16'(pc), 16'h0127);
    check("halt_done2", 16'(done), 16'h0001);
    check("halt_err", 16'(tgt_err), 16'h0001);

    // restart from HALT; start beats stall
    start = 1'b1; start_addr = 10'h000; stall = 1'b1;
    step(); check("restart_pc", 16'(pc), 16'h0000);
    check("restart_done", 16'(done), 16'h0000);
    check("restart_err", 16'(tgt_err), 16'h0000);
    check("restart_stall_fe", 16'(fetch_en), 16'h0000);
    start = 1'b0; stall = 1'b0;

    // same-cycle write and branch read of entry 5
    set_op(4'h7, 8'h00);
    lut_we = 1'b1; lut_waddr = 5'd5; lut_wdata = 10'h055;
    step(); check("w5_pc", 16'(pc), 16'h0001);
    lut_wdata = 10'h2AA; set_op(4'hE, 8'd5);
    step(); check("rdw_old_pc", 16'(pc), 16'h0055);
    check("rdw_old_bt", 16'(branch_taken), 16'h0001);
    lut_we = 1'b0;
    step(); check("rdw_new_pc", 16'(pc), 16'h02AA);
    check("rdw_new_bt", 16'(branch_taken), 16'h0001);
    lut_we = 1'b1; lut_waddr = 5'd0; lut_wdata = 10'h3FF; set_op(4'h7, 8'h00);
    step(); check("w0_pc", 16'(pc), 16'h02AB);
    check("w0_ignored", 16'(dut.lut_q[0]), 16'h0000);

    // PC wrap
    lut_waddr = 5'd7;
    step(); check("w7_pc", 16'(pc), 16'h02AC);
    lut_we = 1'b0; set_op(4'hE, 8'd7);
    step(); check("jmp7_pc", 16'(pc), 16'h03FF);
    set_op(4'h7, 8'h00);
    step(); check("wrap_pc", 16'(pc), 16'h0000);
    check("wrap_err", 16'(tgt_err), 16'h0000);
    check("wrap_bt", 16'(branch_taken), 16'h0000);
    step(); check("post_wrap_pc", 16'(pc), 16'h0001);

    // asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("arst_pc", 16'(pc), 16'h0000);
    check("arst_fetch_en", 16'(fetch_en), 16'h0000);
    check("arst_done", 16'(done), 16'h0000);
    check("arst_lut7", 16'(dut.lut_q[7]), 16'h0000);
    #2 rst_n = 1'b1;
    start = 1'b1; start_addr = 10'h050;
    step(); check("rerun_pc", 16'(pc), 16'h0050);
    start = 1'b0; set_op(4'hE, 8'd3);
    step(); check("lut_cleared_pc", 16'(pc), 16'h0000);
    check("lut_cleared_bt", 16'(branch_taken), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
